// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side VGA timing recovery. Samples HSYNC/VSYNC,
// rebuilds the horizontal/vertical pixel counters (2 clocks behind the
// generator), checks line/frame geometry and reports lock and display-enable.
module vga_sync_decoder #(
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_W     = 96,
  parameter int H_TOTAL      = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_W     = 2,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       HSYNC,
  input  logic       VSYNC,
  output logic [9:0] hori_cnt,
  output logic [9:0] vert_cnt,
  output logic       de,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, SEEK_H, SEEK_V, CHECK, LOCKED} state_t;

  // Geometry constants sized to the counters they are compared against.
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_LOAD = 10'(H_SYNC_START);
  localparam logic [9:0] H_PRE  = 10'(H_SYNC_START - 1);
  localparam logic [9:0] H_END  = 10'(H_SYNC_START + H_SYNC_W - 1);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_LOAD = 10'(V_SYNC_START);
  localparam logic [9:0] V_PRE  = 10'(V_SYNC_START - 1);
  localparam logic [9:0] V_END  = 10'(V_SYNC_START + V_SYNC_W);
  localparam logic [7:0] GOOD_LAST = 8'(LOCK_FRAMES - 1);

  state_t     state;
  logic [7:0] good_frames;
  logic       s_h, s_v, s_h_d, s_v_d;
  logic       v_fall_pend, v_rise_pend;

  logic       h_fall, h_rise, v_fall, v_rise;
  logic       run, line_wrap, v_load, v_rise_due;
  logic       line_chk, frame_chk, h_err, v_err, any_err, lock_nxt;
  logic [9:0] hori_nxt, vert_nxt, vert_inc;

  assign h_fall = s_h_d & ~s_h;
  assign h_rise = ~s_h_d & s_h;
  assign v_fall = s_v_d & ~s_v;
  assign v_rise = ~s_v_d & s_v;

  // Next counter values, geometry checks and the lock decision for this edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    hori_nxt   = '0;
    vert_nxt   = '0;
    vert_inc   = '0;
    line_wrap  = 1'b0;
    v_load     = 1'b0;
    v_rise_due = 1'b0;
    run        = enable && (state != IDLE);
    if (run) begin
      // An HSYNC fall re-phases the line; the wrap is suppressed on that edge.
      line_wrap = (hori_cnt == H_LAST) && !h_fall;
      if (h_fall)                hori_nxt = H_LOAD;
      else if (hori_cnt == H_LAST) hori_nxt = '0;
      else                       hori_nxt = hori_cnt + 10'd1;
      vert_inc = (vert_cnt == V_LAST) ? '0 : vert_cnt + 10'd1;
      // A VSYNC edge seen on the wrap edge itself is honoured immediately.
      v_load     = line_wrap && (v_fall_pend || v_fall);
      v_rise_due = line_wrap && (v_rise_pend || v_rise);
      if (v_load)         vert_nxt = V_LOAD;
      else if (line_wrap) vert_nxt = vert_inc;
      else                vert_nxt = vert_cnt;
    end
    line_chk  = run && (state inside {SEEK_V, CHECK, LOCKED});
    frame_chk = run && (state inside {CHECK, LOCKED});
    h_err = line_chk && ((h_fall && (hori_cnt != H_PRE)) ||
                         (h_rise && (hori_cnt != H_END)));
    v_err = frame_chk && ((v_load && (vert_cnt != V_PRE)) ||
                          (v_rise_due && (vert_nxt != V_END)));
    any_err  = h_err || v_err;
    lock_nxt = run && !any_err &&
               ((state == LOCKED) ||
                ((state == CHECK) && v_load && (good_frames == GOOD_LAST)));
  end

  // Sync capture: one register stage plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Idle level of both syncs is high, so reset must not fake a falling edge.
      s_h   <= 1'b1;
      s_h_d <= 1'b1;
      s_v   <= 1'b1;
      s_v_d <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      s_h   <= HSYNC;
      s_h_d <= s_h;
      s_v   <= VSYNC;
      s_v_d <= s_v;
    end
  end

  // Counters, display enable, error pulse/count and pending VSYNC edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hori_cnt    <= '0;
      vert_cnt    <= '0;
      de          <= 1'b0;
      err         <= 1'b0;
      err_cnt     <= '0;
      v_fall_pend <= 1'b0;
      v_rise_pend <= 1'b0;
    end else begin
      hori_cnt <= hori_nxt;
      vert_cnt <= vert_nxt;
      de       <= lock_nxt && (hori_nxt < H_VIS) && (vert_nxt < V_VIS);
      err      <= any_err;
      if (any_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (!run || line_wrap) begin
        v_fall_pend <= 1'b0;
        v_rise_pend <= 1'b0;
      end else begin
        if (v_fall) v_fall_pend <= 1'b1;
        if (v_rise) v_rise_pend <= 1'b1;
      end
    end
  end

  // Lock FSM: seek line phase, seek frame phase, count clean frames, locked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      good_frames <= '0;
      locked      <= 1'b0;
    end else begin
      locked <= lock_nxt;
      if (!enable) begin
        state       <= IDLE;
        good_frames <= '0;
      end else if (any_err) begin
        state       <= SEEK_H;
        good_frames <= '0;
      end else begin
        case (state)
          IDLE:   state <= SEEK_H;
          SEEK_H: if (h_fall) state <= SEEK_V;
          SEEK_V: if (v_load) begin
            state       <= CHECK;
            good_frames <= '0;
          end
          CHECK:  if (v_load) begin
            if (good_frames == GOOD_LAST) state <= LOCKED;
            else good_frames <= good_frames + 8'd1;
          end
          LOCKED: state <= LOCKED;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: loops a small-geometry VGA generator into the decoder.
// Stimulus pushes expected outputs into queues; a monitor on the falling clock
// edge pops and compares them, and pops an expected err_cnt for every err pulse.
`timescale 1ns/1ps
module tb_vga_sync_decoder;

  localparam int HV = 16, HSS = 20, HSW = 4, HT = 32;
  localparam int VV = 8,  VSS = 10, VSW = 2, VT = 14;
  localparam int LF = 2;
  localparam int FRAME = HT * VT;

  typedef enum int {S_HORI, S_VERT, S_DE, S_LOCKED, S_ERR, S_ERRCNT} sel_t;
  typedef struct {
    string name;
    sel_t  sel;
    int    exp;
  } chk_t;

  chk_t chk_q[$];
  int   err_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       clk = 1'b0;
  logic       reset, enable, HSYNC, VSYNC;
  logic [9:0] hori_cnt, vert_cnt;
  logic       de, locked, err;
  logic [7:0] err_cnt;

  // generator model state
  int g_h, g_v, hw;
  bit gen_en, held, short_all, track_en;
  int stretch_v = -1;
  int short_v   = -1;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_W(HSW), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_W(VSW), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .hori_cnt(hori_cnt), .vert_cnt(vert_cnt), .de(de), .locked(locked),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dut_val(input sel_t s);
    case (s)
      S_HORI:   return int'(hori_cnt);
      S_VERT:   return int'(vert_cnt);
      S_DE:     return int'(de);
      S_LOCKED: return int'(locked);
      S_ERR:    return int'(err);
      default:  return int'(err_cnt);
    endcase
  endfunction

  task automatic expect_out(input string name, input sel_t s, input int v);
    chk_t c;
    c.name = name;
    c.sel  = s;
    c.exp  = v;
    chk_q.push_back(c);
  endtask

  task automatic expect_all_zero(input string tag);
    expect_out({tag, "_hori"},   S_HORI,   0);
    expect_out({tag, "_vert"},   S_VERT,   0);
    expect_out({tag, "_de"},     S_DE,     0);
    expect_out({tag, "_locked"}, S_LOCKED, 0);
    expect_out({tag, "_err"},    S_ERR,    0);
    expect_out({tag, "_errcnt"}, S_ERRCNT, 0);
  endtask

  // Wait (bounded) until the generator sits at (h, v) just after an edge.
  task automatic wait_gen(input string name, input int h, input int v, input int limit);
    bit found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(posedge clk); #2;
      if (g_h == h && (v < 0 || g_v == v)) found = 1'b1;
    end
    check({"wait_", name}, int'(found), 1);
  endtask

  // Wait (bounded) until the monitor has consumed every expected err pulse.
  task automatic wait_err_drain(input string name, input int limit);
    for (int i = 0; i < limit && err_q.size() != 0; i++) begin
      @(posedge clk); #2;
    end
    check({"err_pulses_", name}, err_q.size(), 0);
  endtask

  // First VSYNC load enters CHECK, second is good frame 1, third locks.
  task automatic expect_lock(input string tag);
    wait_gen({tag, "_vs1"}, 2, VSS, 3 * FRAME);
    wait_gen({tag, "_vs2"}, 2, VSS, 2 * FRAME);
    expect_out({tag, "_not_yet"}, S_LOCKED, 0);
    wait_gen({tag, "_vs3"}, 2, VSS, 2 * FRAME);
    expect_out({tag, "_locked"}, S_LOCKED, 1);
    expect_out({tag, "_vert"},   S_VERT,   VSS);
    expect_out({tag, "_hori"},   S_HORI,   0);
    expect_out({tag, "_de"},     S_DE,     0);
  endtask

  // Generator: counters advance 1 ns after each rising edge, syncs follow.
  initial begin
    g_h = 0; g_v = 0; held = 1'b0; hw = HSW;
    HSYNC = 1'b1; VSYNC = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!gen_en) begin
        g_h = 0; g_v = 0; held = 1'b0;
      end else if (g_h == HT - 1 && g_v == stretch_v && !held) begin
        held = 1'b1;
      end else begin
        held = 1'b0;
        if (g_h == HT - 1) begin
          g_h = 0;
          g_v = (g_v == VT - 1) ? 0 : g_v + 1;
        end else begin
          g_h++;
        end
      end
      hw    = (short_all || g_v == short_v) ? HSW - 1 : HSW;
      HSYNC = !(gen_en && g_h >= HSS && g_h < HSS + hw);
      VSYNC = !(gen_en && g_v >= VSS && g_v < VSS + VSW);
    end
  end

  // Monitor: compares queued expectations, err pulses and loop-back tracking.
  initial begin
    chk_t c;
    int   e, eh, ev;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        check(c.name, dut_val(c.sel), c.exp);
      end
      if (err === 1'b1) begin
        if (err_q.size() == 0) begin
          check("unexpected_err", int'(err), 0);
        end else begin
          e = err_q.pop_front();
          check("err_cnt_at_err", int'(err_cnt), e);
          check("locked_at_err", int'(locked), 0);
        end
      end
      if (track_en) begin
        eh = (g_h + HT - 2) % HT;
        ev = (g_h >= 2) ? g_v : (g_v + VT - 1) % VT;
        check("track_hori", int'(hori_cnt), eh);
        check("track_vert", int'(vert_cnt), ev);
        check("track_de",   int'(de), int'(eh < HV && ev < VV));
        check("track_err",  int'(err), 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    reset = 1'b0; enable = 1'b0; gen_en = 1'b0; short_all = 1'b0; track_en = 1'b0;

    // Reset held 3 cycles, then idle with enable low for 100 cycles.
    repeat (3) @(posedge clk);
    #2;
    expect_all_zero("rst");
    @(negedge clk); reset = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    expect_all_zero("idle");

    // Loop-back start: first HSYNC fall loads hori_cnt, then lock and track.
    @(negedge clk); enable = 1'b1; gen_en = 1'b1;
    wait_gen("first_hfall", HSS + 2, -1, 4 * HT);
    expect_out("first_load", S_HORI, HSS);
    expect_lock("lock1");
    track_en = 1'b1;
    repeat (3 * FRAME) @(posedge clk);
    #2;
    track_en = 1'b0;

    // One line stretched by a clock: single line error, relock.
    err_q.push_back(1);
    stretch_v = 3;
    wait_err_drain("stretch", 2 * FRAME);
    stretch_v = -1;
    expect_out("stretch_locked", S_LOCKED, 0);
    expect_lock("relock1");

    // HSYNC pulse one clock short: width error, relock.
    err_q.push_back(2);
    short_v = 5;
    wait_err_drain("short", 2 * FRAME);
    short_v = -1;
    expect_out("short_locked", S_LOCKED, 0);
    expect_out("short_errcnt", S_ERRCNT, 2);
    expect_lock("relock2");

    // Enable dropped mid-line: counters and lock clear, err_cnt kept.
    wait_gen("mid_line", 12, 3, 2 * FRAME);
    expect_out("pre_dis_hori",   S_HORI,   10);
    expect_out("pre_dis_vert",   S_VERT,   3);
    expect_out("pre_dis_de",     S_DE,     1);
    expect_out("pre_dis_locked", S_LOCKED, 1);
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #2;
    expect_out("dis_hori",   S_HORI,   0);
    expect_out("dis_vert",   S_VERT,   0);
    expect_out("dis_de",     S_DE,     0);
    expect_out("dis_locked", S_LOCKED, 0);
    expect_out("dis_errcnt", S_ERRCNT, 2);
    repeat (2) @(posedge clk);
    @(negedge clk); enable = 1'b1;
    expect_lock("relock3");

    // Asynchronous reset mid-frame while locked.
    wait_gen("pre_reset", 12, 4, 2 * FRAME);
    expect_out("pre_reset_de", S_DE, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    expect_all_zero("async_rst");

    // 260 width errors, one per line: err_cnt saturates at 255.
    for (int i = 1; i <= 260; i++) err_q.push_back((i > 255) ? 255 : i);
    @(negedge clk); short_all = 1'b1; reset = 1'b1;
    wait_err_drain("saturate", 300 * HT);
    enable = 1'b0;
    short_all = 1'b0;
    expect_out("sat_errcnt", S_ERRCNT, 255);
    repeat (3) @(posedge clk);
    #2;
    expect_out("sat_hold", S_ERRCNT, 255);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
